// File: rtl/shift_add_mult_8bit_if.sv
// Handshake and data bundle for the 8x8 shift-and-add multiplier.
//   start   : request to begin a multiply (master -> slave)
//   a, b    : unsigned 8-bit operands, sampled with start (master -> slave)
//   ready   : multiplier idle and able to accept start (slave -> master)
//   busy    : multiply iterations in progress (slave -> master)
//   done    : one-cycle pulse, new product valid (slave -> master)
//   product : unsigned 16-bit result, held until the next completion (slave -> master)
interface shift_add_mult_8bit_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (
        output start, a, b,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product
    );
endinterface

// File: rtl/shift_add_mult_8bit.sv
// Sequential 8x8 unsigned multiplier, one shift-and-add iteration per clock.
// Ports:
//   clk : sole clock, rising edge
//   rst : asynchronous active-high reset
//   bus : shift_add_mult_8bit_if.slave (start/a/b in, ready/busy/done/product out)
//
// state | meaning
// IDLE  | waiting for start; ready=1
// RUN   | eight add/shift iterations; busy=1
// DONE  | product just loaded; done=1 for this one cycle
module shift_add_mult_8bit (
    input  logic                  clk,
    input  logic                  rst,
    shift_add_mult_8bit_if.slave  bus
);

    // One-hot encoding so ready/busy/done come straight from state flops.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [7:0]  acc_q,   acc_d;
    logic [7:0]  mq_q,    mq_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [15:0] product_q, product_d;

    logic [8:0]  sum_w;

    // 9-bit add keeps the carry so the shift below never truncates.
    assign sum_w = {1'b0, acc_q} + {1'b0, (mq_q[0] ? mcand_q : 8'h00)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= 8'h00;
            acc_q     <= 8'h00;
            mq_q      <= 8'h00;
            cnt_q     <= 4'd0;
            product_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    mcand_d = bus.a;
                    mq_d    = bus.b;
                    acc_d   = 8'h00;
                    cnt_d   = 4'd0;
                end
            end
            RUN: begin
                // {carry, sum, mq} >> 1 lands in {acc, mq}.
                acc_d = sum_w[8:1];
                mq_d  = {sum_w[0], mq_q[7:1]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    state_d   = DONE;
                    // Capture the post-shift value of the final iteration.
                    product_d = {sum_w, mq_q[7:1]};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready   = state_q[0];
    assign bus.busy    = state_q[1];
    assign bus.done    = state_q[2];
    assign bus.product = product_q;

endmodule
